// File: rtl/cpu16_pkg.sv
// cpu16_pkg: constants and types shared by the cpu16 processor modules.
// Holds the datapath word width, the default output FIFO depth, the
// occupancy state encoding used by out_port_fifo and a saturating
// increment helper for 16-bit event counters.
package cpu16_pkg;

    localparam int WORD_W         = 16;
    localparam int OUT_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_state_t;

    // Saturating +1 on a 16-bit counter; holds at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'h0001;
        end
        return result;
    endfunction

endpackage

// File: rtl/out_port_fifo_if.sv
// out_port_fifo_if: write strobe/data from the processor output path,
// ready/valid read side towards the slow consumer, plus status outputs.
// master = processor/consumer side, slave = the FIFO itself.
interface out_port_fifo_if
    import cpu16_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int WIDTH = WORD_W
) ();

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [LVL_W-1:0] level;
    logic [WIDTH-1:0] last_out;
    logic [15:0]      drop_count;

    modport master (
        output wr_en,
        output wr_data,
        output rd_ready,
        input  full,
        input  rd_valid,
        input  rd_data,
        input  level,
        input  last_out,
        input  drop_count
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_ready,
        output full,
        output rd_valid,
        output rd_data,
        output level,
        output last_out,
        output drop_count
    );

endinterface

// File: rtl/out_fifo_ram.sv
// out_fifo_ram: DEPTH x WIDTH storage for out_port_fifo.
// Synchronous write, asynchronous read by index. Contents are never
// cleared; the owning FIFO tracks which entries are valid.
module out_fifo_ram
    import cpu16_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int WIDTH = WORD_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the incoming word at the write index on an accepted write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// out_port_fifo: first-word fall-through FIFO between the processor's
// output instruction and a slower consumer. Occupancy is kept as an
// explicit level counter with an EMPTY/PARTIAL/FULL state register; the
// pointers are never compared. Writes into a full FIFO are rejected even
// when a read happens in the same cycle. last_out mirrors the most
// recently accepted word for the legacy out register behaviour.
// Optional feature: define OUT_FIFO_DROP_COUNT_EN to build a saturating
// counter of rejected writes on drop_count; otherwise drop_count is 0.
module out_port_fifo
    import cpu16_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    out_port_fifo_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH - 1);

    occ_state_t       state_r;
    occ_state_t       state_nxt_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic             full_r;
    logic             rd_valid_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [WIDTH-1:0] last_out_r;
    logic [WIDTH-1:0] ram_rdata_s;
    logic             wr_acc_s;
    logic             rd_acc_s;

    // Handshake acceptance uses only registered flags, so a write into a
    // full FIFO is refused regardless of a same-cycle read.
    assign wr_acc_s = bus.wr_en && !full_r;
    assign rd_acc_s = rd_valid_r && bus.rd_ready;

    out_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // Next occupancy count: +1 on write only, -1 on read only, else hold.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Occupancy state transitions driven by accepted reads and writes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            OCC_EMPTY: begin
                if (wr_acc_s) begin
                    state_nxt_s = OCC_PARTIAL;
                end else begin
                    state_nxt_s = OCC_EMPTY;
                end
            end
            OCC_PARTIAL: begin
                if (wr_acc_s && !rd_acc_s && (level_r == LVL_LAST)) begin
                    state_nxt_s = OCC_FULL;
                end else if (rd_acc_s && !wr_acc_s && (level_r == LVL_ONE)) begin
                    state_nxt_s = OCC_EMPTY;
                end else begin
                    state_nxt_s = OCC_PARTIAL;
                end
            end
            OCC_FULL: begin
                if (rd_acc_s) begin
                    state_nxt_s = OCC_PARTIAL;
                end else begin
                    state_nxt_s = OCC_FULL;
                end
            end
            default: state_nxt_s = OCC_EMPTY;
        endcase
    end

    // State, level and the registered status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= OCC_EMPTY;
            level_r    <= LVL_ZERO;
            full_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            level_r    <= level_nxt_s;
            full_r     <= (state_nxt_s == OCC_FULL);
            rd_valid_r <= (state_nxt_s != OCC_EMPTY);
        end
    end

    // Write pointer and legacy last_out copy advance on accepted writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            last_out_r <= {WIDTH{1'b0}};
        end else if (wr_acc_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            last_out_r <= bus.wr_data;
        end
    end

    // Read pointer advances on accepted reads; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

`ifdef OUT_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count_r;

    // Count rejected writes, saturating at all-ones; cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_r <= 16'h0000;
        end else if (bus.wr_en && full_r) begin
            drop_count_r <= sat_inc16(drop_count_r);
        end
    end

    assign bus.drop_count = drop_count_r;
`else
    assign bus.drop_count = 16'h0000;
`endif

    assign bus.full     = full_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = ram_rdata_s;
    assign bus.level    = level_r;
    assign bus.last_out = last_out_r;

endmodule
